sram_port_arbiter: RTL
======================

// Module: sram_port_arbiter
// PURPOSE
//  Shares one single-port SRAM (1-cycle read latency) between the core's instruction-fetch and data ports.
//  Both core-side ports use the req/gnt/rvalid protocol; each accepted request returns exactly one rvalid.
//  Data port has priority; a streak counter guarantees forward progress for fetch.
//  Requests outside the memory window complete with err and make no SRAM access.
//  Sits between ibex_top and the single-port SRAM in the FPGA top level.
// PARAMETERS
//  MemSize        65536         SRAM size in bytes (power of two, >= 8)
//  MemStart       32'h00000000  base address of SRAM window (MemSize-aligned)
//  MaxDataStreak  4             max consecutive data grants while fetch is waiting (>= 1)
//  AddrWidth      $clog2(MemSize/4)  localparam, word-address width
// PORTS
//  clk_i           in   1          clock
//  rst_i           in   1          synchronous reset, active-high
//  instr_req_i     in   1          fetch request
//  instr_gnt_o     out  1          fetch grant (combinational, same cycle)
//  instr_rvalid_o  out  1          fetch response valid
//  instr_addr_i    in   32         fetch byte address
//  instr_rdata_o   out  32         fetch read data
//  instr_err_o     out  1          fetch error, valid with rvalid
//  data_req_i      in   1          data request
//  data_gnt_o      out  1          data grant (combinational, same cycle)
//  data_rvalid_o   out  1          data response valid (reads and writes)
//  data_we_i       in   1          write enable
//  data_be_i       in   4          byte enables
//  data_addr_i     in   32         data byte address
//  data_wdata_i    in   32         write data
//  data_rdata_o    out  32         read data
//  data_err_o      out  1          data error, valid with rvalid
//  ram_req_o       out  1          SRAM access strobe
//  ram_we_o        out  1          SRAM write enable
//  ram_be_o        out  4          SRAM byte enables
//  ram_addr_o      out  AddrWidth  SRAM word address = addr[AddrWidth+1:2]
//  ram_wdata_o     out  32         SRAM write data
//  ram_rdata_i     in   32         SRAM read data, valid 1 cycle after read ram_req_o
// BEHAVIOUR
//  - At most one grant per cycle. Grant data if data_req_i and (!instr_req_i or streak < MaxDataStreak), else grant instr if instr_req_i.
//  - streak: counts data grants made while instr_req_i was high; cleared on any instr grant or any cycle instr_req_i is low; saturates at MaxDataStreak.
//  - In range: (addr & ~(MemSize-1)) == MemStart. A granted in-range request drives ram_req_o the same cycle, with ram_we_o = data_we_i (0 for fetch), ram_be_o = data_be_i (4'hF for fetch) and wdata passed through.
//  - Out-of-range grant: ram_req_o=0; next cycle rvalid=1, err=1, rdata=0.
//  - Response: registered owner {NONE, INSTR, DATA} plus err flag. rvalid fires on the owner's port exactly 1 cycle after gnt. rdata = ram_rdata_i when err=0. The non-owner port sees rvalid=0 and rdata=0.
//  - Back-to-back grants every cycle are allowed; throughput is 1 access/cycle.
//  - Reset (rst_i=1): owner=NONE, err=0, streak=0. All outputs are 0: gnt, rvalid, err, rdata, ram_*. Grants are suppressed during reset. An access granted the cycle before reset asserts produces no rvalid.
//  - gnt depends combinationally on req and addr only. No combinational path from ram_rdata_i to any gnt.
// STRUCTURE
//  - sram_arb_pkg: owner_e enum {OWN_NONE, OWN_INSTR, OWN_DATA}; MemWordBytes=4 constant.
//  - Sub-module sram_arb_prio2: 2-way fixed-priority arbiter with streak counter and starvation override.
//    Outputs one-hot grant; instantiated once.
//  - Top-level file: address decode, RAM mux, response register and demux.
// TESTING
//  1 Data-only read at 0x100 (ram holds 0xDEADBEEF at word 0x40): gnt same cycle, ram_addr=0x40, next cycle data_rvalid=1, rdata=0xDEADBEEF, err=0.
//  2 Both ports request continuously, MaxDataStreak=4: grant pattern D,D,D,D,I repeating; instr_rvalid count = 1 per 5 cycles.
//  3 Data write addr 0x4, be=4'b0010, wdata=0x0000AB00: ram_we=1, be=0010, data_rvalid next cycle with err=0; readback 0x4 shows byte1=0xAB.
//  4 Fetch at 0x0001_0000 (MemSize=64KiB): instr_gnt=1, ram_req=0, next cycle instr_rvalid=1, err=1, rdata=0.
//  5 rst_i asserted the cycle after a data grant: no data_rvalid; all outputs 0 during reset; first post-reset request is serviced normally.
//  6 Alternate instr-only and data-only single requests every cycle: each sees gnt same cycle and exactly one rvalid next cycle on the correct port.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter.
//   owner_e      : which core port owns the response due next cycle
//   MemWordBytes : bytes per SRAM word
//   PortInstr/PortData : bit positions in the arbiter request/grant vectors
package sram_arb_pkg;

    localparam int unsigned MemWordBytes = 4;
    localparam int unsigned PortInstr    = 0;
    localparam int unsigned PortData     = 1;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_INSTR = 2'd1,
        OWN_DATA  = 2'd2
    } owner_e;

endpackage

// File: rtl/sram_arb_prio2.sv
// Two-way fixed-priority arbiter: data (req[PortData]) wins unless it has
// already taken MaxStreak grants in a row while fetch was waiting.
// Ports:
//   clk, rst : clock, synchronous active-high reset (grants suppressed)
//   req[1:0] : requests, indexed by PortInstr/PortData
//   gnt[1:0] : one-hot grant, combinational from req and streak state
module sram_arb_prio2
    import sram_arb_pkg::*;
#(
    parameter int unsigned MaxStreak = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    localparam int unsigned StreakWidth = $clog2(MaxStreak + 1);
    localparam logic [StreakWidth-1:0] StreakMax = StreakWidth'(MaxStreak);

    logic [StreakWidth-1:0] streak_q;
    logic [StreakWidth-1:0] streak_d;

    // Grant selection and streak update
    always_comb begin
        gnt      = '0;
        streak_d = streak_q;
        if (!rst) begin
            if (req[PortData] && (!req[PortInstr] || (streak_q < StreakMax))) begin
                gnt[PortData] = 1'b1;
            end else if (req[PortInstr]) begin
                gnt[PortInstr] = 1'b1;
            end
        end
        // Streak only measures how long fetch has been kept waiting
        if (!req[PortInstr] || gnt[PortInstr]) begin
            streak_d = '0;
        end else if (gnt[PortData] && (streak_q < StreakMax)) begin
            streak_d = streak_q + StreakWidth'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM (1-cycle read latency) between the fetch and
// data ports of the core. Data has priority with a bounded streak; requests
// outside the SRAM window are granted but answered with err and no access.
// Ports:
//   clk_i, rst_i                      : clock, synchronous active-high reset
//   instr_req/gnt/rvalid/addr/rdata/err : fetch port (req/gnt/rvalid)
//   data_req/gnt/rvalid/we/be/addr/wdata/rdata/err : data port
//   ram_req/we/be/addr/wdata, ram_rdata_i : SRAM side, word addressed
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned MemSize       = 65536,
    parameter logic [31:0] MemStart      = 32'h0000_0000,
    parameter int unsigned MaxDataStreak = 4,
    localparam int unsigned AddrWidth    = $clog2(MemSize / MemWordBytes)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 instr_req_i,
    output logic                 instr_gnt_o,
    output logic                 instr_rvalid_o,
    input  logic [31:0]          instr_addr_i,
    output logic [31:0]          instr_rdata_o,
    output logic                 instr_err_o,
    input  logic                 data_req_i,
    output logic                 data_gnt_o,
    output logic                 data_rvalid_o,
    input  logic                 data_we_i,
    input  logic [3:0]           data_be_i,
    input  logic [31:0]          data_addr_i,
    input  logic [31:0]          data_wdata_i,
    output logic [31:0]          data_rdata_o,
    output logic                 data_err_o,
    output logic                 ram_req_o,
    output logic                 ram_we_o,
    output logic [3:0]           ram_be_o,
    output logic [AddrWidth-1:0] ram_addr_o,
    output logic [31:0]          ram_wdata_o,
    input  logic [31:0]          ram_rdata_i
);

    localparam logic [31:0] AddrMask = ~(32'(MemSize) - 32'd1);

    logic   instr_in_range;
    logic   data_in_range;
    logic   [1:0] req;
    logic   [1:0] gnt;
    owner_e owner_q;
    owner_e owner_d;
    logic   err_q;
    logic   err_d;

    assign instr_in_range = (instr_addr_i & AddrMask) == MemStart;
    assign data_in_range  = (data_addr_i & AddrMask) == MemStart;

    assign req[PortInstr] = instr_req_i;
    assign req[PortData]  = data_req_i;

    sram_arb_prio2 #(
        .MaxStreak (MaxDataStreak)
    ) u_prio (
        .clk (clk_i),
        .rst (rst_i),
        .req (req),
        .gnt (gnt)
    );

    assign instr_gnt_o = gnt[PortInstr];
    assign data_gnt_o  = gnt[PortData];

    // RAM request mux and next response owner
    always_comb begin
        ram_req_o   = 1'b0;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        owner_d     = OWN_NONE;
        err_d       = 1'b0;
        if (gnt[PortData]) begin
            owner_d = OWN_DATA;
            err_d   = !data_in_range;
            if (data_in_range) begin
                ram_req_o   = 1'b1;
                ram_we_o    = data_we_i;
                ram_be_o    = data_be_i;
                ram_addr_o  = data_addr_i[AddrWidth+1:2];
                ram_wdata_o = data_wdata_i;
            end
        end else if (gnt[PortInstr]) begin
            owner_d = OWN_INSTR;
            err_d   = !instr_in_range;
            if (instr_in_range) begin
                ram_req_o  = 1'b1;
                ram_be_o   = 4'hF;
                ram_addr_o = instr_addr_i[AddrWidth+1:2];
            end
        end
    end

    // Response owner register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner_q <= OWN_NONE;
            err_q   <= 1'b0;
        end else begin
            owner_q <= owner_d;
            err_q   <= err_d;
        end
    end

    // Response demux; gated by reset so an access granted just before reset is dropped
    always_comb begin
        instr_rvalid_o = 1'b0;
        instr_err_o    = 1'b0;
        instr_rdata_o  = '0;
        data_rvalid_o  = 1'b0;
        data_err_o     = 1'b0;
        data_rdata_o   = '0;
        if (!rst_i) begin
            case (owner_q)
                OWN_INSTR: begin
                    instr_rvalid_o = 1'b1;
                    instr_err_o    = err_q;
                    instr_rdata_o  = err_q ? 32'd0 : ram_rdata_i;
                end
                OWN_DATA: begin
                    data_rvalid_o = 1'b1;
                    data_err_o    = err_q;
                    data_rdata_o  = err_q ? 32'd0 : ram_rdata_i;
                end
                default: ;
            endcase
        end
    end

endmodule
